// File: rtl/debug_scanner.sv
// debug_scanner: host-side initiator for the mips debug port.
// Single-steps the core and sweeps its debug address space onto a stream.
module debug_scanner #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 128,
  parameter int SETTLE    = 2,
  parameter int AUTO_SCAN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_mode,
  input  logic              step_req,
  input  logic              scan_start,
  output logic              debug_en,
  output logic              debug_step,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                en_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  // State, address, settle counter and capture registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= ~run_mode;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next-state: step wins over scan; a new word starts only on handshake.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      IDLE: begin
        if (step_req && en_q) begin
          state_d = STEP;
        end else if (scan_start) begin
          state_d = WAIT;
          addr_d  = '0;
          cnt_d   = CNT_LOAD;
        end
      end
      STEP: begin
        if (AUTO_SCAN != 0) begin
          state_d = WAIT;
          addr_d  = '0;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rd_data_d = debug_data;
          rd_addr_d = addr_q;
          state_d   = OUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OUT: begin
        if (rd_ready) begin
          if (addr_q == LAST) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT;
            addr_d  = addr_q + 1'b1;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign debug_en   = en_q;
  assign debug_step = (state_q == STEP);
  assign debug_addr = addr_q;
  assign rd_valid   = (state_q == OUT);
  assign rd_addr    = rd_addr_q;
  assign rd_data    = rd_data_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_debug_scanner.sv
// tb_debug_scanner: directed bench for debug_scanner.
// Covers scan, back-pressure, step, collisions, reset and SETTLE=1.
module tb_debug_scanner;

  logic        clk = 1'b0;
  logic        rst, run_mode, step_req, scan_start, rd_ready;
  logic        debug_en, debug_step, rd_valid, busy;
  logic [6:0]  debug_addr, rd_addr;
  logic [31:0] debug_data, rd_data;

  logic        s2_start, s2_nostep, s2_en, s2_step;
  logic        s2_valid, s2_ready, s2_busy;
  logic [6:0]  s2_dbg_addr, s2_addr;
  logic [31:0] s2_core, s2_data;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int n_steps = 0;

  always #5 clk = ~clk;

  debug_scanner dut (
    .clk(clk), .rst(rst), .run_mode(run_mode),
    .step_req(step_req), .scan_start(scan_start),
    .debug_en(debug_en), .debug_step(debug_step),
    .debug_addr(debug_addr), .debug_data(debug_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  debug_scanner #(.SETTLE(1), .AUTO_SCAN(0)) dut2 (
    .clk(clk), .rst(rst), .run_mode(run_mode),
    .step_req(s2_nostep), .scan_start(s2_start),
    .debug_en(s2_en), .debug_step(s2_step),
    .debug_addr(s2_dbg_addr), .debug_data(s2_core),
    .rd_valid(s2_valid), .rd_ready(s2_ready),
    .rd_addr(s2_addr), .rd_data(s2_data), .busy(s2_busy)
  );

  // Core model: one cycle of read latency on the debug port.
  always_ff @(posedge clk)
    debug_data <= 32'hA500_0000 | 32'(debug_addr);

  assign s2_core = 32'h5A00_0000 | 32'(s2_dbg_addr);

  always_ff @(posedge clk)
    if (debug_step) n_steps <= n_steps + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic scan_run(input int t0, input int n,
                          input int bp_k, input bit noisy);
    int words = 0;
    int lim = 0;
    int hold = 0;
    int xtra;
    rd_ready = 1'b1;
    while (words < n && lim < 3000) begin
      if (noisy) begin
        step_req   = (lim % 50 == 20);
        scan_start = (lim % 50 == 20);
      end
      if (rd_valid) begin
        if (int'(rd_addr) == bp_k && hold < 10) begin
          rd_ready = 1'b0;
          check("bp_hold",
                {rd_valid, rd_addr, rd_data, debug_addr},
                {1'b1, 7'(bp_k), 32'hA500_0000 | 32'(bp_k), 7'(bp_k)});
          hold++;
        end else begin
          rd_ready = 1'b1;
          xtra = (bp_k >= 0 && words >= bp_k) ? 10 : 0;
          check("rd_addr", rd_addr, words);
          check("rd_data", rd_data, 32'hA500_0000 | 32'(words));
          check("hs_cycle", cyc, t0 + 3 + 3 * words + xtra);
          words++;
        end
      end
      tick();
      lim++;
    end
    step_req   = 1'b0;
    scan_start = 1'b0;
    rd_ready   = 1'b1;
    check("scan_words", words, n);
  endtask

  initial begin
    int t0, s0, w, lim, seen;
    rst = 1'b0; run_mode = 1'b1; step_req = 1'b0;
    scan_start = 1'b0; rd_ready = 1'b1;
    s2_start = 1'b0; s2_nostep = 1'b0; s2_ready = 1'b1;
    repeat (3) tick();
    check("rst_out",
          {debug_en, debug_step, debug_addr, rd_valid,
           rd_addr, rd_data, busy}, '0);
    check("rst_out2",
          {s2_en, s2_step, s2_dbg_addr, s2_valid,
           s2_addr, s2_data, s2_busy}, '0);
    rst = 1'b1;
    tick();
    check("en_run", debug_en, 0);
    run_mode = 1'b0;
    tick();
    check("en_dbg", debug_en, 1);

    // Full scan with back-pressure on word 5.
    t0 = cyc;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("scan_entry", {busy, debug_addr}, {1'b1, 7'd0});
    scan_run(t0, 128, 5, 1'b0);
    check("scan_done", {busy, rd_valid, debug_addr}, {2'b00, 7'd127});

    // Single step with auto scan.
    t0 = cyc;
    s0 = n_steps;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("step_pulse", {debug_step, busy}, 2'b11);
    tick();
    check("step_wait", {debug_step, busy, debug_addr}, {2'b01, 7'd0});
    scan_run(t0 + 1, 128, -1, 1'b0);
    check("step_count", n_steps - s0, 1);

    // Step in run mode is ignored.
    run_mode = 1'b1;
    tick();
    tick();
    check("en_off", debug_en, 0);
    s0 = n_steps;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("run_step", {debug_step, busy}, 2'b00);
    tick();
    check("run_idle", {busy, 32'(n_steps - s0)}, '0);
    run_mode = 1'b0;
    tick();
    tick();

    // Step and scan together, extra requests during the scan.
    t0 = cyc;
    s0 = n_steps;
    step_req = 1'b1;
    scan_start = 1'b1;
    tick();
    step_req = 1'b0;
    scan_start = 1'b0;
    check("both_step", {debug_step, busy}, 2'b11);
    scan_run(t0 + 1, 128, -1, 1'b1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy || rd_valid) seen++;
      tick();
    end
    check("no_extra", seen, 0);
    check("both_count", n_steps - s0, 1);

    // Reset in OUT at word 40.
    t0 = cyc;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    scan_run(t0, 40, -1, 1'b0);
    rd_ready = 1'b0;
    lim = 0;
    while (!rd_valid && lim < 10) begin
      tick();
      lim++;
    end
    check("at_w40", {rd_valid, rd_addr}, {1'b1, 7'd40});
    rst = 1'b0;
    tick();
    check("mid_rst",
          {debug_en, debug_step, debug_addr, rd_valid,
           rd_addr, rd_data, busy}, '0);
    rst = 1'b1;
    rd_ready = 1'b1;
    tick();
    check("post_rst", {busy, debug_en}, 2'b01);
    t0 = cyc;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("restart", {busy, debug_addr}, {1'b1, 7'd0});
    scan_run(t0, 128, -1, 1'b0);

    // SETTLE=1 instance: 2-cycle period.
    t0 = cyc;
    s2_start = 1'b1;
    tick();
    s2_start = 1'b0;
    w = 0;
    lim = 0;
    while (w < 128 && lim < 1000) begin
      if (s2_valid) begin
        check("s1_addr", s2_addr, w);
        check("s1_data", s2_data, 32'h5A00_0000 | 32'(w));
        check("s1_cycle", cyc, t0 + 2 + 2 * w);
        w++;
      end
      tick();
      lim++;
    end
    check("s1_words", w, 128);
    check("s1_done", s2_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_scanner.md
# debug_scanner

Host-side initiator for the CPU debug port: drives `debug_en`, `debug_step` and `debug_addr` into the `mips` core and reads back `debug_data`. Sweeps the debug address space on request or after each single step, presenting each captured word on a valid/ready stream to a downstream display or serial dumper. Sits in the board top level between the debounced button/switch logic and the `mips` instance.

## Interface
Parameters:
- `ADDR_W`, 7: debug address width.
- `DATA_W`, 32: debug data width.
- `NUM_WORDS`, 128: words per scan, covering addresses 0..NUM_WORDS-1; NUM_WORDS ≤ 2^ADDR_W.
- `SETTLE`, 2: cycles `debug_addr` is held before `debug_data` is sampled; legal range ≥ 1.
- `AUTO_SCAN`, 1: 1 = start a scan automatically after every single step.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `run_mode` in 1: 1 = CPU free-runs, 0 = debug/single-step mode. Level input.
- `step_req` in 1: one-cycle single-step request, already debounced.
- `scan_start` in 1: one-cycle scan request.
- `debug_en` out 1: to core; registered inverse of `run_mode`.
- `debug_step` out 1: to core; one-cycle step pulse.
- `debug_addr` out ADDR_W: to core.
- `debug_data` in DATA_W: from core.
- `rd_valid` out 1: captured word available.
- `rd_ready` in 1: downstream accepts the word.
- `rd_addr` out ADDR_W: address of the captured word.
- `rd_data` out DATA_W: captured word.
- `busy` out 1: a step or scan is in progress.

## Operation
- Reset (`rst`=0 at an edge): all outputs 0. The FSM goes to IDLE and the counters clear. This overrides any operation in progress, including mid-scan and mid-handshake. The word pending on `rd_valid` is dropped.
- `debug_en` <= `~run_mode` every cycle, outside reset. A mode change mid-scan does not abort the scan.
- FSM states: IDLE, STEP, WAIT, OUT.
- IDLE:
  - `step_req`=1 with `debug_en`=1 → STEP.
  - Otherwise `scan_start`=1 → WAIT, with `debug_addr`=0 and the settle counter loaded.
  - If both are high, the step wins and `scan_start` is dropped.
  - `step_req` with `debug_en`=0 is ignored.
- STEP: `debug_step`=1 for exactly this cycle.
  - Next state: WAIT at address 0 if AUTO_SCAN=1, else IDLE.
- WAIT: `debug_addr` held for SETTLE cycles. At the edge ending the last one, `rd_data`<=`debug_data`, `rd_addr`<=`debug_addr`, → OUT.
- OUT: `rd_valid`=1. `rd_data` and `rd_addr` are held stable until `rd_valid`&&`rd_ready`. On the handshake edge:
  - If `debug_addr`=NUM_WORDS-1 → IDLE, clearing `rd_valid` and `busy`.
  - Otherwise `debug_addr`+1 → WAIT.
- `busy`=1 in STEP, WAIT and OUT.
- `step_req` and `scan_start` are ignored while `busy`=1. They are not queued.
- `debug_addr` changes only on entry to WAIT. It holds its last value in IDLE.
- Address increment is ADDR_W-bit unsigned. It never wraps within a scan because the scan terminates at NUM_WORDS-1.

## Timing
- `scan_start` sampled at edge t (end of cycle t):
  - `busy`=1 and `debug_addr`=0 in cycle t+1.
  - Data sampled at the end of cycle t+SETTLE.
  - `rd_valid`=1 from cycle t+SETTLE+1.
- Per word with `rd_ready` held at 1: period SETTLE+1 cycles.
- Full scan: the last handshake is in cycle t+NUM_WORDS·(SETTLE+1), and `busy`=0 the cycle after. With defaults, last handshake at t+384 and `busy` low at t+385.
- Back-pressure: each cycle of `rd_ready`=0 in OUT adds one cycle. Nothing else in the block stalls.
- `step_req` at edge t:
  - `debug_step`=1 and `busy`=1 in cycle t+1 only.
  - With AUTO_SCAN=1, `debug_addr`=0 (WAIT) from cycle t+2; the scan then follows the scan timing above with t replaced by t+1.
- `run_mode` change at edge t is reflected on `debug_en` in cycle t+1.

## Test plan
- Reset, then hold `rd_ready`=1 and pulse `scan_start` at edge t, with a core model returning `debug_data`=0xA5000000|addr. Expect 128 handshakes in order: word k at cycle t+3+3k with `rd_addr`=k and `rd_data`=0xA5000000|k. `busy` falls at t+385.
- Back-pressure: hold `rd_ready`=0 for 10 cycles on word 5. `rd_valid`, `rd_addr`=5 and `rd_data` stay constant throughout, `debug_addr` stays 5, and no word is skipped or duplicated.
- `run_mode`=0, pulse `step_req` with AUTO_SCAN=1. Expect `debug_en`=1, exactly one `debug_step` pulse, then a full scan. With `run_mode`=1, `step_req` gives no `debug_step` and `busy` stays 0.
- `step_req` and `scan_start` high in the same cycle, in debug mode: one step, one scan. Extra `scan_start` and `step_req` pulses during the scan are ignored; exactly 128 words total.
- Assert `rst`=0 while in OUT at word 40. The next cycle, all outputs are 0 and the state is IDLE. A new `scan_start` restarts at address 0.
- SETTLE=1 build: per-word period is 2 cycles, and `debug_data` is sampled with `debug_addr` stable for exactly 1 cycle.
